// File: rtl/hpi_arb_pkg.sv
// Shared types and constants for the CY7C67200 HPI access arbiter.
package hpi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } hpi_state_e;

  localparam int REQ_NIOS = 0;
  localparam int REQ_HW   = 1;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // One-hot round-robin pick; on contention the requester that did not win last time goes.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
    case (valid)
      2'b01:   rr_pick = 2'b01;
      2'b10:   rr_pick = 2'b10;
      2'b11:   rr_pick = last ? 2'b01 : 2'b10;
      default: rr_pick = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hpi_cycle_sequencer.sv
// Runs one timed HPI bus cycle (setup/strobe/hold/recovery) with registered pad
// outputs, captures read data at the end of the strobe and pulses done.
module hpi_cycle_sequencer
  import hpi_arb_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2,
  parameter int CNT_W        = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] pad_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic        cs_n_o,
  output logic        r_n_o,
  output logic        w_n_o,
  output logic [1:0]  addr_o,
  output logic [15:0] data_o,
  output logic        oe_o
);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LAST    = CNT_W'(RECOVERY_CYC - 1);

  hpi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       cap_q, cap_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              cs_n_q, cs_n_d;
  logic              r_n_q, r_n_d;
  logic              w_n_q, w_n_d;
  logic [1:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    write_d = write_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    cs_n_d  = cs_n_q;
    r_n_d   = r_n_q;
    w_n_d   = w_n_q;
    addr_d  = addr_q;
    data_d  = data_q;
    oe_d    = oe_q;
    // Pad values are loaded on the edge entering each phase so they are clean registers.
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = ST_SETUP;
          write_d = write_i;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          addr_d  = addr_i;
          data_d  = write_i ? wdata_i : 16'h0000;
          oe_d    = write_i;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
          r_n_d   = write_q;
          w_n_d   = ~write_q;
        end
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          r_n_d   = 1'b1;
          w_n_d   = 1'b1;
          cap_d   = pad_data_i;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          data_d  = 16'h0000;
          done_d  = 1'b1;
          rdata_d = write_q ? 16'h0000 : cap_q;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == REC_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        r_n_d   = 1'b1;
        w_n_d   = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cap_q   <= 16'h0000;
      rdata_q <= 16'h0000;
      cs_n_q  <= 1'b1;
      r_n_q   <= 1'b1;
      w_n_q   <= 1'b1;
      addr_q  <= HPI_DATA;
      data_q  <= 16'h0000;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      cs_n_q  <= cs_n_d;
      r_n_q   <= r_n_d;
      w_n_q   <= w_n_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oe_q    <= oe_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign cs_n_o  = cs_n_q;
  assign r_n_o   = r_n_q;
  assign w_n_o   = w_n_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign oe_o    = oe_q;

endmodule

// File: rtl/hpi_access_arbiter.sv
// Round-robin sharing of the OTG HPI port between the Nios PIO bridge (0) and
// the hardware keyboard poller (1); responses are steered back to the owner.
module hpi_access_arbiter
  import hpi_arb_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2,
  parameter int CNT_W        = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][1:0]  req_addr,
  input  logic [1:0][15:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic [15:0]      rsp_rdata,
  output logic             busy,
  output logic             otg_hpi_cs_n,
  output logic             otg_hpi_r_n,
  output logic             otg_hpi_w_n,
  output logic [1:0]       otg_hpi_address,
  output logic [15:0]      otg_hpi_data_out,
  output logic             otg_hpi_data_oe,
  input  logic [15:0]      otg_hpi_data_in
);

  logic       last_grant_q, last_grant_d;
  logic [1:0] grant;
  logic       sel;
  logic       handshake;
  logic       seq_busy;
  logic       seq_done;

  assign grant     = rr_pick(req_valid, last_grant_q);
  assign req_ready = seq_busy ? 2'b00 : grant;
  assign handshake = |(req_valid & req_ready);
  assign sel       = grant[REQ_HW];

  // last_grant doubles as the owner of the access in flight: it only moves on a handshake.
  always_comb begin
    last_grant_d = last_grant_q;
    if (handshake) last_grant_d = sel;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) last_grant_q <= 1'b1;
    else             last_grant_q <= last_grant_d;
  end

  hpi_cycle_sequencer #(
    .SETUP_CYC    (SETUP_CYC),
    .STROBE_CYC   (STROBE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .RECOVERY_CYC (RECOVERY_CYC),
    .CNT_W        (CNT_W)
  ) u_seq (
    .clk_i      (clk_clk),
    .rst_i      (reset_reset),
    .start_i    (handshake),
    .write_i    (req_write[sel]),
    .addr_i     (req_addr[sel]),
    .wdata_i    (req_wdata[sel]),
    .pad_data_i (otg_hpi_data_in),
    .busy_o     (seq_busy),
    .done_o     (seq_done),
    .rdata_o    (rsp_rdata),
    .cs_n_o     (otg_hpi_cs_n),
    .r_n_o      (otg_hpi_r_n),
    .w_n_o      (otg_hpi_w_n),
    .addr_o     (otg_hpi_address),
    .data_o     (otg_hpi_data_out),
    .oe_o       (otg_hpi_data_oe)
  );

  assign rsp_valid[REQ_HW]   = seq_done & last_grant_q;
  assign rsp_valid[REQ_NIOS] = seq_done & ~last_grant_q;
  assign busy                = seq_busy;

endmodule

// File: doc/hpi_access_arbiter.md
Name: hpi_access_arbiter

Overview:
- Shares the single CY7C67200 OTG HPI port between two requesters: requester 0 is the Nios software PIO bridge; requester 1 is a hardware keyboard poller.
- Arbitrates between them round-robin.
- Sequences each granted access as a timed HPI bus cycle (setup / strobe / hold / recovery) and returns read data or a write acknowledge to the owner.
- Sits between nios_system and the top-level OTG pins.

Parameters:
- SETUP_CYC, 1, cycles with cs_n low and address/data valid before the strobe (must be >=1).
- STROBE_CYC, 4, cycles r_n/w_n is held low (must be >=1).
- HOLD_CYC, 1, cycles cs_n, address and data are held after the strobe rises (must be >=1).
- RECOVERY_CYC, 2, cycles cs_n is high between accesses (must be >=1).
- CNT_W, 4, phase counter width; must hold max(param)-1.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester access request.
- req_ready  out  2  per-requester accept; a transfer occurs when valid&ready.
- req_write  in  2  1 = write, 0 = read, per requester.
- req_addr  in  2x2  HPI register address, per requester.
- req_wdata  in  2x16  write data, per requester.
- rsp_valid  out  2  one-cycle completion pulse, per requester.
- rsp_rdata  out  16  read data, shared, valid with rsp_valid (0 for writes).
- busy  out  1  high whenever the FSM is not IDLE.
- otg_hpi_cs_n  out  1  HPI chip select.
- otg_hpi_r_n  out  1  read strobe.
- otg_hpi_w_n  out  1  write strobe.
- otg_hpi_address  out  2  HPI address.
- otg_hpi_data_out  out  16  write data to the pad.
- otg_hpi_data_oe  out  1  pad output enable.
- otg_hpi_data_in  in  16  read data from the pad.

Behaviour:
- Reset (asynchronous, immediate) forces these values:
  - otg_hpi_cs_n, otg_hpi_r_n and otg_hpi_w_n = 1.
  - otg_hpi_data_oe = 0.
  - otg_hpi_address and otg_hpi_data_out = 0.
  - req_ready, rsp_valid and rsp_rdata = 0; busy = 0.
  - FSM = IDLE; last_grant = 1, so requester 0 wins first.
- A reset mid-access aborts it; no rsp_valid is issued.
- All outputs except req_ready are registered. req_ready is combinational: high only in IDLE, and only for the granted requester.
- Arbitration in IDLE:
  - If only one valid, grant it.
  - If both valid, grant the requester != last_grant.
  - last_grant updates only on a handshake.
- A requester may drop valid before ready without effect.
- Payload is sampled only at the handshake; afterwards it may change.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE. Each non-IDLE state lasts its parameter in cycles, counted by the phase counter.
- SETUP:
  - cs_n = 0; address driven.
  - For writes: data_out = wdata and oe = 1.
  - r_n and w_n stay high.
- STROBE: r_n (read) or w_n (write) is 0.
- Read data: otg_hpi_data_in is registered on the clock edge that ends the last STROBE cycle.
- HOLD:
  - Strobes are high.
  - cs_n, address, data and oe are unchanged.
- RECOVER:
  - cs_n = 1; oe = 0; data_out = 0.
  - rsp_valid[owner] pulses for exactly the first RECOVER cycle.
  - rsp_rdata = the captured data for reads, 0 for writes; it holds until the next response.
- Latency with defaults (handshake in cycle 0):
  - SETUP: cycle 1.
  - STROBE: cycles 2-5.
  - HOLD: cycle 6.
  - RECOVER: cycles 7-8, with rsp_valid in cycle 7.
  - IDLE again in cycle 9; the next handshake is possible in cycle 9.
  - General period = 1 + SETUP + STROBE + HOLD + RECOVERY.
- cs_n and the strobes never glitch low outside an access, and r_n and w_n are never low together.
- A new request arriving during an access waits. There is no queueing beyond valid/ready.

Decomposition:
- Shared package hpi_arb_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - REQ_NIOS = 0 and REQ_HW = 1;
  - HPI address constants: DATA = 0, MAILBOX = 1, ADDRESS = 2, STATUS = 3.
- One sub-module, hpi_cycle_sequencer, contains the FSM, the phase counter, pad registers and read capture, with a start/write/addr/wdata in, done/rdata out interface.
- The top level holds the round-robin grant logic and response steering.

Test Plan:
- Single read: req 0 reads addr 3 with otg_hpi_data_in = 16'hBEEF during the strobe -> r_n low in cycles 2-5, rsp_valid[0] in cycle 7 with rsp_rdata = 16'hBEEF, and w_n stays 1 throughout.
- Single write: req 1 writes 16'h1234 to addr 2 -> oe = 1 and data_out = 16'h1234 in cycles 1-6, w_n low in cycles 2-5, rsp_valid[1] in cycle 7 with rsp_rdata = 0.
- Contention: both valid continuously from reset -> grants alternate 0,1,0,1, with handshakes 9 cycles apart.
- Withdrawn request: req 1 asserts valid while busy, then drops it before IDLE -> no access is issued and last_grant is unchanged.
- Reset mid-access: assert reset_reset during STROBE -> cs_n, r_n and w_n = 1 and oe = 0 immediately; no rsp_valid; after release, req 0 is granted first.
- Parameter sweep: SETUP/STROBE/HOLD/RECOVERY = 2/1/3/1 -> phase lengths match exactly and rsp_valid arrives 7 cycles after the handshake.
